// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC, fetches 32-bit words over a req/ack handshake into a small
// prefetch FIFO, presents the head instruction to decode and applies the
// decoder's pcsel redirect, flushing wrong-path words.
// Optional build macro: FETCH_PERF_EN adds fetch_count / flush_count outputs.
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              stall,
    input  logic [1:0]        pcsel,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [ADDR_W-1:0] instr_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       flush_count,
`endif
    output logic [ADDR_W-1:0] pc_plus4
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC_C  = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] START_PC_C = {RESET_PC[ADDR_W-1:2], 2'b00};

    // Fetch-side state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;

    // Prefetch FIFO storage and pointers
    logic [31:0]       data_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Control strobes
    logic              valid_s;
    logic              consume_s;
    logic              redirect_s;
    logic              xfer_s;
    logic              push_s;
    logic              pop_s;
    logic              busy_after_s;
    logic              issue_s;
    logic [31:0]       head_instr_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic              unused_s;

    // The low two target bits never reach the PC: fetches are word aligned.
    assign unused_s = ^target[1:0];

    // Handshake, consume and redirect decoding.
    always_comb begin
        valid_s    = (count_q != {CNT_W{1'b0}});
        consume_s  = valid_s && !stall;
        redirect_s = consume_s && ((pcsel == 2'b01) || (pcsel == 2'b11) ||
                                   ((pcsel == 2'b10) && branch_taken));
        xfer_s     = req_q && imem_ack;
        // A word landing on a redirect edge, or while discarding, is wrong-path.
        push_s     = xfer_s && !discard_q && !redirect_s;
        pop_s      = consume_s && !redirect_s;
        // Request still pending after this edge (at most one is ever in flight).
        busy_after_s = req_q && !imem_ack;
    end

    // FIFO pointer/count next state; a redirect flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Request issue and PC next state. Issue looks at the post-edge count so a
    // word popped this edge frees its slot immediately (1 instr/cycle).
    // No issue on a redirect edge or while a stale word is being discarded, so
    // imem_req always drops for a cycle before the target fetch.
    always_comb begin
        issue_s    = !busy_after_s && !redirect_s && !discard_q &&
                     (count_d < DEPTH_C);
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        discard_d  = discard_q;
        if (redirect_s) begin
            fetch_pc_d = {target[ADDR_W-1:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + PC_INC_C;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        if (issue_s) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
        end else if (busy_after_s) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = 1'b0;
            addr_d = addr_q;
        end
        if (redirect_s) begin
            discard_d = busy_after_s;
        end else if (xfer_s && discard_q) begin
            discard_d = 1'b0;
        end else begin
            discard_d = discard_q;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            fetch_pc_q <= START_PC_C;
            req_q      <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i] <= 32'd0;
                pc_mem_q[i]   <= {ADDR_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_q[wr_ptr_q] <= imem_rdata;
                pc_mem_q[wr_ptr_q]   <= addr_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] flush_count_q;

    // Performance counters: words pushed and redirects taken, wrapping at 2^32.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            fetch_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            if (push_s) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (redirect_s) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

    // Head outputs come straight from the FIFO head and read zero when empty.
    always_comb begin
        if (valid_s) begin
            head_instr_s = data_mem_q[rd_ptr_q];
            head_pc_s    = pc_mem_q[rd_ptr_q];
        end else begin
            head_instr_s = 32'd0;
            head_pc_s    = {ADDR_W{1'b0}};
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_s;
    assign instr       = head_instr_s;
    assign opcode      = head_instr_s[6:0];
    assign funct3      = head_instr_s[14:12];
    assign funct7      = head_instr_s[31:25];
    assign instr_pc    = head_pc_s;
    assign pc_plus4    = valid_s ? (head_pc_s + PC_INC_C) : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Two instances share stimulus: u_dut (RESET_PC=0) and u_wrap
// (RESET_PC=0xFFFFFFF8) for the address wrap and reset-refetch cases.
module tb_fetch_unit;

    logic        clock;
    logic        nReset;
    logic        stall;
    logic [1:0]  pcsel;
    logic        branch_taken;
    logic [31:0] target;
    logic        imem_ack;

    logic        imem_req,    w_imem_req;
    logic [31:0] imem_addr,   w_imem_addr;
    logic [31:0] imem_rdata,  w_imem_rdata;
    logic        instr_valid, w_instr_valid;
    logic [31:0] instr,       w_instr;
    logic [6:0]  opcode,      w_opcode;
    logic [2:0]  funct3,      w_funct3;
    logic [6:0]  funct7,      w_funct7;
    logic [31:0] instr_pc,    w_instr_pc;
    logic [31:0] pc_plus4,    w_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, w_fetch_count;
    logic [31:0] flush_count, w_flush_count;
`endif

    int tests;
    int failed;

    // Memory model: each word is its address XORed with a fixed tag.
    assign imem_rdata   = imem_addr   ^ 32'hDEAD_0000;
    assign w_imem_rdata = w_imem_addr ^ 32'hDEAD_0000;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clock(clock), .nReset(nReset), .stall(stall), .pcsel(pcsel),
        .branch_taken(branch_taken), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .instr_pc(instr_pc),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count), .flush_count(flush_count),
`endif
        .pc_plus4(pc_plus4)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clock(clock), .nReset(nReset), .stall(stall), .pcsel(pcsel),
        .branch_taken(branch_taken), .target(target),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
        .imem_rdata(w_imem_rdata), .instr_valid(w_instr_valid), .instr(w_instr),
        .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
        .instr_pc(w_instr_pc),
`ifdef FETCH_PERF_EN
        .fetch_count(w_fetch_count), .flush_count(w_flush_count),
`endif
        .pc_plus4(w_pc_plus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        nReset       = 1'b1;
        stall        = 1'b0;
        pcsel        = 2'b00;
        branch_taken = 1'b0;
        target       = 32'h0;
        imem_ack     = 1'b0;
        #1 nReset = 1'b0;
        #2;
        // Reset state
        check("rst_req",   64'(imem_req),    64'h0);
        check("rst_addr",  64'(imem_addr),   64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_instr", 64'(instr),       64'h0);
        check("rst_pc",    64'(instr_pc),    64'h0);
        check("rst_pc4",   64'(pc_plus4),    64'h0);
        check("rst_op",    64'({opcode, funct3, funct7}), 64'h0);

        // Release, ack tied high, no stall
        @(negedge clock);
        nReset   = 1'b1;
        imem_ack = 1'b1;
        step();
        check("e1_req",    64'(imem_req),    64'h1);
        check("e1_addr",   64'(imem_addr),   64'h0);
        check("e1_valid",  64'(instr_valid), 64'h0);
        check("e1_waddr",  64'(w_imem_addr), 64'hFFFF_FFF8);
        step();
        check("e2_addr",   64'(imem_addr),   64'h4);
        check("e2_valid",  64'(instr_valid), 64'h1);
        check("e2_pc",     64'(instr_pc),    64'h0);
        check("e2_instr",  64'(instr),       64'hDEAD_0000);
        check("e2_pc4",    64'(pc_plus4),    64'h4);
        check("e2_waddr",  64'(w_imem_addr), 64'hFFFF_FFFC);
        check("e2_wpc",    64'(w_instr_pc),  64'hFFFF_FFF8);
        step();
        check("e3_addr",   64'(imem_addr),   64'h8);
        check("e3_pc",     64'(instr_pc),    64'h4);
        check("e3_waddr",  64'(w_imem_addr), 64'h0);
        check("e3_wpc",    64'(w_instr_pc),  64'hFFFF_FFFC);
        check("e3_wpc4",   64'(w_pc_plus4),  64'h0);
        step();
        check("e4_addr",   64'(imem_addr),   64'hC);
        check("e4_pc",     64'(instr_pc),    64'h8);
        check("e4_opcode", 64'(opcode),      64'h08);
        check("e4_funct3", 64'(funct3),      64'h0);
        check("e4_funct7", 64'(funct7),      64'h6F);
        check("e4_wpc",    64'(w_instr_pc),  64'h0);

        // Stall 5 cycles: FIFO fills with 0x8,0xC and the request stops
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req",   64'(imem_req), 64'h0);
            check("stall_pc",    64'(instr_pc), 64'h8);
            check("stall_instr", 64'(instr),    64'hDEAD_0008);
        end
        stall = 1'b0;
        step();
        check("rel_pc",   64'(instr_pc),  64'hC);
        check("rel_req",  64'(imem_req),  64'h1);
        check("rel_addr", 64'(imem_addr), 64'h10);
        step();
        check("rel2_pc",   64'(instr_pc),  64'h10);
        check("rel2_addr", 64'(imem_addr), 64'h14);

        // Branch not taken: sequential flow continues
        pcsel        = 2'b10;
        branch_taken = 1'b0;
        target       = 32'h200;
        step();
        check("bnt_pc",    64'(instr_pc),    64'h14);
        check("bnt_valid", 64'(instr_valid), 64'h1);
        check("bnt_addr",  64'(imem_addr),   64'h18);

        // Branch taken to 0x43: fetch at 0x40, word for 0x18 dropped
        branch_taken = 1'b1;
        target       = 32'h43;
        step();
        pcsel        = 2'b00;
        branch_taken = 1'b0;
        check("bt_valid", 64'(instr_valid), 64'h0);
        check("bt_req",   64'(imem_req),    64'h0);
        step();
        check("bt1_req",   64'(imem_req),    64'h1);
        check("bt1_addr",  64'(imem_addr),   64'h40);
        check("bt1_valid", 64'(instr_valid), 64'h0);
        step();
        check("bt2_valid", 64'(instr_valid), 64'h1);
        check("bt2_pc",    64'(instr_pc),    64'h40);
        check("bt2_instr", 64'(instr),       64'hDEAD_0040);
        check("bt2_addr",  64'(imem_addr),   64'h44);

        // JAL to 0x100 with the 0x44 request in flight (ack held low)
        imem_ack = 1'b0;
        pcsel    = 2'b11;
        target   = 32'h100;
        step();
        pcsel = 2'b00;
        check("jal_valid", 64'(instr_valid), 64'h0);
        check("jal_req",   64'(imem_req),    64'h1);
        check("jal_addr",  64'(imem_addr),   64'h44);
        step();
        check("jal1_valid", 64'(instr_valid), 64'h0);
        check("jal1_addr",  64'(imem_addr),   64'h44);
        imem_ack = 1'b1;
        step();
        check("jal2_valid", 64'(instr_valid), 64'h0);
        check("jal2_req",   64'(imem_req),    64'h0);
        step();
        check("jal3_req",   64'(imem_req),    64'h1);
        check("jal3_addr",  64'(imem_addr),   64'h100);
        check("jal3_valid", 64'(instr_valid), 64'h0);
        step();
        check("jal4_valid", 64'(instr_valid), 64'h1);
        check("jal4_pc",    64'(instr_pc),    64'h100);
        check("jal4_instr", 64'(instr),       64'hDEAD_0100);

        // Ack delayed 3 cycles on the 0x104 request
        imem_ack = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dly_req",  64'(imem_req),  64'h1);
            check("dly_addr", 64'(imem_addr), 64'h104);
            check("dly_pc",   64'(instr_pc),  64'h100);
        end
        imem_ack = 1'b1;
        step();
        check("dack_req", 64'(imem_req), 64'h0);
        check("dack_pc",  64'(instr_pc), 64'h100);
        imem_ack = 1'b0;
        stall    = 1'b0;
        step();
        check("dpop_pc",   64'(instr_pc),  64'h104);
        check("dpop_addr", 64'(imem_addr), 64'h108);
        step();
        check("dpop2_valid", 64'(instr_valid), 64'h0);
        check("dpop2_req",   64'(imem_req),    64'h1);
`ifdef FETCH_PERF_EN
        check("perf_fetch", 64'(fetch_count), 64'd9);
        check("perf_flush", 64'(flush_count), 64'd2);
`endif

        // Reset mid-request: outputs clear at once, refetch from RESET_PC
        #2 nReset = 1'b0;
        #1;
        check("mrst_req",   64'(imem_req),    64'h0);
        check("mrst_addr",  64'(imem_addr),   64'h0);
        check("mrst_valid", 64'(instr_valid), 64'h0);
        check("mrst_instr", 64'(instr),       64'h0);
        check("mrst_wreq",  64'(w_imem_req),  64'h0);
        check("mrst_wpc",   64'(w_instr_pc),  64'h0);
        imem_ack = 1'b1;
        @(negedge clock);
        nReset = 1'b1;
        step();
        check("rf_req",   64'(imem_req),    64'h1);
        check("rf_addr",  64'(imem_addr),   64'h0);
        check("rf_waddr", 64'(w_imem_addr), 64'hFFFF_FFF8);
        check("rf_valid", 64'(instr_valid), 64'h0);
        step();
        check("rf2_pc",  64'(instr_pc),   64'h0);
        check("rf2_wpc", 64'(w_instr_pc), 64'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
        check("perf_fetch_rst", 64'(fetch_count), 64'd1);
        check("perf_flush_rst", 64'(flush_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
